// File: rtl/path_tracer_if.sv
// Stack pop port and forward-order move stream of the path tracer.
// master = path_tracer, slave = direction stack plus downstream path consumer.
interface path_tracer_if;
    logic       stk_empty;
    logic [1:0] stk_pop;
    logic       stk_do_pop;
    logic [1:0] dir_out;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  stk_empty, stk_pop, out_ready,
        output stk_do_pop, dir_out, out_valid
    );

    modport slave (
        output stk_empty, stk_pop, out_ready,
        input  stk_do_pop, dir_out, out_valid
    );
endinterface

// File: rtl/path_tracer.sv
// Drains the direction stack, then replays the moves start-to-goal over a valid/ready stream.
// Optional coordinate tracking of the rat is enabled with `define PATH_TRACER_COORD_EN.
module path_tracer #(
    parameter int DEPTH = 256,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    path_tracer_if.master    bus,
    output logic [CW-1:0]    x,
    output logic [CW-1:0]    y,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP_REQ = 3'd1,
        POP_CAP = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  count_r;
    logic [IDX_W-1:0]  idx_r;
    logic [1:0]        buf_r [DEPTH];
    logic              drain_end_s;
    logic              hs_s;
    logic              restart_s;

    // Draining also stops once the buffer is full, whatever the stack says.
    assign drain_end_s = bus.stk_empty || (count_r == CNT_FULL);
    assign hs_s        = (state_r == EMIT) && bus.out_ready;
    assign restart_s   = start && ((state_r == IDLE) || (state_r == DONE));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = start ? POP_REQ : IDLE;
            POP_REQ: begin
                if (drain_end_s) begin
                    state_nxt_s = (count_r == {CNT_W{1'b0}}) ? DONE : EMIT;
                end else begin
                    state_nxt_s = POP_CAP;
                end
            end
            POP_CAP: state_nxt_s = POP_REQ;
            EMIT:    state_nxt_s = (hs_s && (idx_r == IDX_ZERO)) ? DONE : EMIT;
            DONE:    state_nxt_s = start ? POP_REQ : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        bus.stk_do_pop = 1'b0;
        bus.out_valid  = 1'b0;
        bus.dir_out    = 2'b00;
        busy           = 1'b0;
        done           = 1'b0;
        case (state_r)
            IDLE:    busy = 1'b0;
            POP_REQ: begin
                busy           = 1'b1;
                bus.stk_do_pop = !drain_end_s;
            end
            POP_CAP: busy = 1'b1;
            EMIT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.dir_out   = buf_r[idx_r];
            end
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Drain counter and replay index; replay runs from the oldest move (highest index) down.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            idx_r   <= IDX_ZERO;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        count_r <= {CNT_W{1'b0}};
                        idx_r   <= IDX_ZERO;
                    end
                end
                POP_REQ: begin
                    if (drain_end_s) begin
                        idx_r <= IDX_W'(count_r - CNT_ONE);
                    end
                end
                POP_CAP: count_r <= count_r + CNT_ONE;
                EMIT: begin
                    if (hs_s && (idx_r != IDX_ZERO)) begin
                        idx_r <= idx_r - IDX_ONE;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Move buffer; buf_r[0] receives the stack top (the final move of the path).
    always_ff @(posedge clk) begin
        if (!rst && (state_r == POP_CAP)) begin
            buf_r[count_r[IDX_W-1:0]] <= bus.stk_pop;
        end
    end

`ifdef PATH_TRACER_COORD_EN
    localparam logic [CW-1:0] CO_ONE = CW'(1);
    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;

    // Rat position; arithmetic wraps modulo 2^CW by design.
    always_ff @(posedge clk) begin
        if (rst || restart_s) begin
            x_r <= {CW{1'b0}};
            y_r <= {CW{1'b0}};
        end else if (hs_s) begin
            case (buf_r[idx_r])
                2'b00:   y_r <= y_r - CO_ONE;
                2'b01:   x_r <= x_r + CO_ONE;
                2'b10:   x_r <= x_r - CO_ONE;
                2'b11:   y_r <= y_r + CO_ONE;
                default: x_r <= x_r;
            endcase
        end
    end

    assign x = x_r;
    assign y = y_r;
`else
    logic unused_restart_s;
    assign unused_restart_s = restart_s;
    assign x = {CW{1'b0}};
    assign y = {CW{1'b0}};
`endif

endmodule
